// File: rtl/dds_freq_meter.sv
// dds_freq_meter: measures n_per periods of a DDS waveform via hysteretic rising-crossing detection;
// define FREQ_METER_AMP_EN to build peak amplitude tracking (otherwise peak_max/peak_min are 0)
module dds_freq_meter #(
    parameter int          DATA_W  = 10,
    parameter int          MID     = 512,
    parameter int          HYST    = 16,
    parameter logic [23:0] TMO_CYC = 24'hFFFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        n_per,
    input  logic [DATA_W-1:0] wave_in,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       period_sum,
    output logic [DATA_W-1:0] peak_max,
    output logic [DATA_W-1:0] peak_min
);
    typedef enum logic [1:0] {IDLE, SYNC, COUNT, DONE} state_t;
    localparam logic [DATA_W-1:0] LO_TH = DATA_W'(MID - HYST);
    localparam logic [DATA_W-1:0] HI_TH = DATA_W'(MID + HYST);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] s_q;
    logic              lo_q, lo_d, rise;
    logic [3:0]        n_q, n_d, cross_q, cross_d;
    logic [31:0]       cyc_q, cyc_d, sum_q, sum_d;
    logic [23:0]       tmo_q, tmo_d;
    logic              timeout_q, timeout_d;
    assign rise       = lo_q && (s_q >= HI_TH);
    assign busy       = (state_q == SYNC) || (state_q == COUNT);
    assign done       = state_q == DONE;
    assign timeout    = timeout_q;
    assign period_sum = sum_q;
    // next-state: crossing arm flag, FSM, period/cycle/timeout counters
    always_comb begin
        state_d   = state_q;
        lo_d      = rise ? 1'b0 : (s_q < LO_TH) ? 1'b1 : lo_q;
        n_d       = n_q;
        cross_d   = cross_q;
        cyc_d     = cyc_q;
        sum_d     = sum_q;
        tmo_d     = tmo_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = SYNC;
                n_d     = (n_per == 4'd0) ? 4'd1 : n_per;
                cross_d = '0;
                cyc_d   = '0;
                tmo_d   = '0;
                lo_d    = 1'b0;
            end
            SYNC: begin
                tmo_d = rise ? '0 : tmo_q + 24'd1;
                if (rise) begin
                    state_d = COUNT;
                    cyc_d   = 32'd1;
                end else if (tmo_q == TMO_CYC) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            COUNT: begin
                cyc_d = (&cyc_q) ? cyc_q : cyc_q + 32'd1;
                tmo_d = rise ? '0 : tmo_q + 24'd1;
                if (rise) begin
                    cross_d = cross_q + 4'd1;
                    if (cross_q + 4'd1 == n_q) begin
                        state_d = DONE;
                        sum_d   = cyc_q;
                    end
                end else if (tmo_q == TMO_CYC) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // state and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            s_q       <= '0;
            lo_q      <= 1'b0;
            n_q       <= '0;
            cross_q   <= '0;
            cyc_q     <= '0;
            sum_q     <= '0;
            tmo_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= wave_in;
            lo_q      <= lo_d;
            n_q       <= n_d;
            cross_q   <= cross_d;
            cyc_q     <= cyc_d;
            sum_q     <= sum_d;
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
        end
    end
`ifdef FREQ_METER_AMP_EN
    logic [DATA_W-1:0] max_q, max_d, min_q, min_d, pmax_q, pmax_d, pmin_q, pmin_d;
    logic              to_done, to_count;
    assign to_done  = (state_q == COUNT) && (state_d == DONE);
    assign to_count = (state_q == SYNC) && rise;
    assign peak_max = pmax_q;
    assign peak_min = pmin_q;
    // running extremes over COUNT, published when the measurement completes
    always_comb begin
        max_d  = to_count ? '0 : (state_q == COUNT && s_q > max_q) ? s_q : max_q;
        min_d  = to_count ? '1 : (state_q == COUNT && s_q < min_q) ? s_q : min_q;
        pmax_d = to_done ? max_d : pmax_q;
        pmin_d = to_done ? min_d : pmin_q;
    end
    // amplitude registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q  <= '0;
            min_q  <= '0;
            pmax_q <= '0;
            pmin_q <= '0;
        end else begin
            max_q  <= max_d;
            min_q  <= min_d;
            pmax_q <= pmax_d;
            pmin_q <= pmin_d;
        end
    end
`else
    assign peak_max = '0;
    assign peak_min = '0;
`endif
endmodule
